bep_frame_sequencer: RTL and testbench

//  Sequences the BEP pulse-width datapath: syncs digital_in, times each high pulse, classifies it as bit 0/1,

---
 rtl/bep_pkg.sv | 30 +++
 rtl/bep_pulse_timer.sv | 54 +++++
 rtl/bep_frame_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_bep_frame_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bep_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bep_pkg: shared BEP state encoding, default timing and pulse classification.
// Revision: 1.0
// ----------------------------------------------------------------------------
package bep_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    GAP     = 2'd2
  } bep_state_e;

  localparam int BEP_MIN_TIMING  = 9;
  localparam int BEP_MAX_TIMING  = 18;
  localparam int BEP_GAP_TIMEOUT = 40;
  localparam int BEP_WORD_BITS   = 8;
  localparam int BEP_TIMER_W     = 8;

  // Nearest nominal width wins; equal distance resolves to a 1 bit.
  function automatic logic bep_classify(input int width, input int min_t, input int max_t);
    int d_min;
    int d_max;
    d_min = (width > min_t) ? width - min_t : min_t - width;
    d_max = (width > max_t) ? width - max_t : max_t - width;
    return (d_min < d_max) ? 1'b0 : 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bep_pulse_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bep_pulse_timer: synchronises the BEP line, detects edges, times high pulses.
// Revision: 1.0
// ----------------------------------------------------------------------------
module bep_pulse_timer
  import bep_pkg::*;
#(
  parameter int TIMER_W = BEP_TIMER_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               line_i,
  output logic               rise_o,
  output logic               width_done_o,
  output logic [TIMER_W-1:0] width_o
);

  localparam logic [TIMER_W-1:0] c_sat = '1;

  logic               sync1_q;
  logic               sync2_q;
  logic               level_q;
  logic [TIMER_W-1:0] cnt_q;
  logic [TIMER_W-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    if (sync2_q) begin
      cnt_d = (cnt_q == c_sat) ? cnt_q : cnt_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      level_q <= sync2_q;
      cnt_q   <= cnt_d;
    end
  end

  // On the falling-edge cycle cnt_q still holds the full high width.
  assign rise_o       = sync2_q & ~level_q;
  assign width_done_o = ~sync2_q & level_q;
  assign width_o      = cnt_q;

endmodule
`default_nettype wire

// File: rtl/bep_frame_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bep_frame_sequencer: BEP bit/word/frame decoder with valid/ready output and
// sticky errors. Option macro BEP_PARITY_EN adds a trailing even-parity bit.
// Revision: 1.0
// ----------------------------------------------------------------------------
module bep_frame_sequencer
  import bep_pkg::*;
#(
  parameter int MIN_TIMING  = BEP_MIN_TIMING,
  parameter int MAX_TIMING  = BEP_MAX_TIMING,
  parameter int GAP_TIMEOUT = BEP_GAP_TIMEOUT,
  parameter int WORD_BITS   = BEP_WORD_BITS,
  parameter int TIMER_W     = BEP_TIMER_W
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 digital_in,
  output logic [WORD_BITS-1:0] word_data,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic                 frame_active,
  output logic                 frame_end,
  input  logic                 clear_errors,
  output logic                 pulse_error,
  output logic                 overrun_error,
  output logic                 partial_error,
  output logic                 parity_error
);

  localparam logic [TIMER_W-1:0] c_width_lo = TIMER_W'(MIN_TIMING / 2);
  localparam logic [TIMER_W-1:0] c_width_hi = TIMER_W'(MAX_TIMING + MIN_TIMING / 2);
  localparam logic [TIMER_W-1:0] c_sat      = '1;
  localparam logic [TIMER_W-1:0] c_gap_last = TIMER_W'(GAP_TIMEOUT - 1);
`ifdef BEP_PARITY_EN
  localparam int c_slots = WORD_BITS + 1;
  localparam int c_sh_w  = WORD_BITS;
`else
  localparam int c_slots = WORD_BITS;
  localparam int c_sh_w  = WORD_BITS - 1;
`endif
  localparam int                 c_cnt_w = $clog2(c_slots + 1);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(c_slots - 1);

  logic               w_rise;
  logic               w_done;
  logic [TIMER_W-1:0] w_width;

  bep_pulse_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clock        (clock),
    .reset_n      (reset_n),
    .line_i       (digital_in),
    .rise_o       (w_rise),
    .width_done_o (w_done),
    .width_o      (w_width)
  );

  bep_state_e           state_q, state_d;
  logic [TIMER_W-1:0]   gap_q, gap_d;
  logic [c_cnt_w-1:0]   bit_cnt_q, bit_cnt_d;
  logic [c_sh_w-1:0]    shift_q, shift_d;
  logic [WORD_BITS-1:0] word_q, word_d;
  logic                 valid_q, valid_d;
  logic                 active_q, active_d;
  logic                 fend_q, fend_d;
  // {pulse, overrun, partial, parity}
  logic [3:0]           err_q, err_d, w_err_set;

  logic                 w_accept;
  logic                 w_bit;
  logic                 w_emit;
  logic                 w_ok;
  logic [WORD_BITS-1:0] w_word;

  assign w_accept = (w_width >= c_width_lo) && (w_width <= c_width_hi) && (w_width != c_sat);
  assign w_bit    = bep_classify(int'(w_width), MIN_TIMING, MAX_TIMING);

`ifdef BEP_PARITY_EN
  assign w_word = shift_q;
  assign w_ok   = ~(^{shift_q, w_bit});
`else
  assign w_word = {shift_q, w_bit};
  assign w_ok   = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    word_d    = word_q;
    valid_d   = valid_q;
    active_d  = active_q;
    fend_d    = 1'b0;
    w_err_set = 4'b0000;
    w_emit    = 1'b0;

    if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (w_rise) state_d = MEASURE;
      end
      MEASURE: begin
        if (w_done) begin
          gap_d = '0;
          if (w_accept) begin
            w_emit   = 1'b1;
            active_d = 1'b1;
            state_d  = GAP;
          end else begin
            w_err_set[3] = 1'b1;
            state_d      = active_q ? GAP : IDLE;
          end
        end
      end
      GAP: begin
        if (w_rise) begin
          state_d = MEASURE;
        end else if (gap_q == c_gap_last) begin
          state_d      = IDLE;
          fend_d       = 1'b1;
          active_d     = 1'b0;
          w_err_set[1] = (bit_cnt_q != '0);
          bit_cnt_d    = '0;
          shift_d      = '0;
        end else begin
          gap_d = (gap_q == c_sat) ? gap_q : gap_q + TIMER_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A completed word is dropped if the previous one is still waiting.
    if (w_emit) begin
      if (bit_cnt_q == c_last) begin
        bit_cnt_d = '0;
        shift_d   = '0;
        if (!w_ok) begin
          w_err_set[0] = 1'b1;
        end else if (valid_q && !word_ready) begin
          w_err_set[2] = 1'b1;
        end else begin
          word_d  = w_word;
          valid_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + c_cnt_w'(1);
        shift_d   = {shift_q[c_sh_w-2:0], w_bit};
      end
    end

    err_d = (err_q & {4{~clear_errors}}) | w_err_set;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gap_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
      fend_q    <= 1'b0;
      err_q     <= 4'b0000;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
      fend_q    <= fend_d;
      err_q     <= err_d;
    end
  end

  assign word_data     = word_q;
  assign word_valid    = valid_q;
  assign frame_active  = active_q;
  assign frame_end     = fend_q;
  assign pulse_error   = err_q[3];
  assign partial_error = err_q[1];
  assign overrun_error = err_q[2];
  assign parity_error  = err_q[0];

endmodule
`default_nettype wire

// File: tb/tb_bep_frame_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bep_frame_sequencer: directed bench for bep_frame_sequencer (BEP_PARITY_EN aware).
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_bep_frame_sequencer;

  logic       clock;
  logic       reset_n;
  logic       digital_in;
  logic [7:0] word_data;
  logic       word_valid;
  logic       word_ready;
  logic       frame_active;
  logic       frame_end;
  logic       clear_errors;
  logic       pulse_error;
  logic       overrun_error;
  logic       partial_error;
  logic       parity_error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] w_status;
  logic [3:0] w_errors;
  assign w_status = {word_valid, frame_active, frame_end,
                     pulse_error, overrun_error, partial_error, parity_error};
  assign w_errors = {pulse_error, overrun_error, partial_error, parity_error};

  bep_frame_sequencer u_dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .digital_in    (digital_in),
    .word_data     (word_data),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .frame_active  (frame_active),
    .frame_end     (frame_end),
    .clear_errors  (clear_errors),
    .pulse_error   (pulse_error),
    .overrun_error (overrun_error),
    .partial_error (partial_error),
    .parity_error  (parity_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // High for w clock edges, then low; optionally assert word_ready exactly
  // in the cycle where the resulting word would load.
  task automatic pulse(input int w, input int gap, input bit rdy_at_load);
    digital_in = 1'b1;
    tick(w);
    digital_in = 1'b0;
    if (rdy_at_load) begin
      tick(2);
      word_ready = 1'b1;
      tick(1);
      word_ready = 1'b0;
      tick(gap - 3);
    end else begin
      tick(gap);
    end
  endtask

  task automatic send_byte(input logic [7:0] data, input bit rdy_last, input bit bad_parity);
    logic [8:0] slots;
    int         n;
`ifdef BEP_PARITY_EN
    slots = {data, (^data) ^ bad_parity};
    n     = 9;
`else
    slots = {data, bad_parity};
    n     = 8;
`endif
    for (int i = 8; i > 8 - n; i--) begin
      pulse(slots[i] ? 18 : 9, 10, rdy_last && (i == 9 - n));
    end
  endtask

  task automatic accept();
    word_ready = 1'b1;
    tick(1);
    word_ready = 1'b0;
  endtask

  task automatic clear();
    clear_errors = 1'b1;
    tick(1);
    clear_errors = 1'b0;
  endtask

  task automatic wait_frame_end(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      tick(1);
      if (frame_end) found = 1'b1;
    end
    check(tag, 32'(found), 32'h1);
    check({tag, "_inactive"}, 32'(frame_active), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    digital_in   = 1'b0;
    word_ready   = 1'b0;
    clear_errors = 1'b0;
    reset_n      = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    check("reset_status", 32'(w_status), 32'h0);
    check("reset_data", 32'(word_data), 32'h0);

    // Nominal frame
    send_byte(8'hA5, 1'b0, 1'b0);
    check("a5_valid", 32'(word_valid), 32'h1);
    check("a5_data", 32'(word_data), 32'hA5);
    check("a5_active", 32'(frame_active), 32'h1);
    wait_frame_end("a5_frame_end");
    check("a5_errors", 32'(w_errors), 32'h0);
    accept();
    check("a5_released", 32'(word_valid), 32'h0);

    // Classification thresholds and rejected widths
    pulse(13, 10, 1'b0);
    pulse(14, 10, 1'b0);
    check("pulse_err_before", 32'(pulse_error), 32'h0);
    pulse(3, 10, 1'b0);
    check("narrow_pulse_err", 32'(pulse_error), 32'h1);
    clear();
    check("clear_pulse_err", 32'(pulse_error), 32'h0);
    pulse(23, 10, 1'b0);
    check("wide_pulse_err", 32'(pulse_error), 32'h1);
    pulse(4, 10, 1'b0);
    pulse(22, 10, 1'b0);
    pulse(18, 10, 1'b0);
    pulse(9, 10, 1'b0);
    pulse(9, 10, 1'b0);
    pulse(18, 10, 1'b0);
`ifdef BEP_PARITY_EN
    pulse(9, 10, 1'b0);
`endif
    check("thresh_valid", 32'(word_valid), 32'h1);
    check("thresh_data", 32'(word_data), 32'h59);
    accept();
    wait_frame_end("thresh_frame_end");
    clear();
    check("thresh_cleared", 32'(w_errors), 32'h0);

    // Overrun, then a load coinciding with acceptance
    send_byte(8'h12, 1'b0, 1'b0);
    send_byte(8'h34, 1'b0, 1'b0);
    check("overrun_err", 32'(overrun_error), 32'h1);
    check("overrun_data", 32'(word_data), 32'h12);
    check("overrun_valid", 32'(word_valid), 32'h1);
    accept();
    check("overrun_released", 32'(word_valid), 32'h0);
    clear();
    check("overrun_cleared", 32'(overrun_error), 32'h0);
    send_byte(8'h56, 1'b0, 1'b0);
    check("held_data", 32'(word_data), 32'h56);
    send_byte(8'h78, 1'b1, 1'b0);
    check("same_cycle_valid", 32'(word_valid), 32'h1);
    check("same_cycle_data", 32'(word_data), 32'h78);
    check("same_cycle_no_overrun", 32'(overrun_error), 32'h0);
    accept();
    wait_frame_end("overrun_frame_end");

    // Partial word at timeout
    pulse(18, 10, 1'b0);
    pulse(9, 10, 1'b0);
    pulse(18, 10, 1'b0);
    pulse(18, 10, 1'b0);
    pulse(9, 10, 1'b0);
    wait_frame_end("partial_frame_end");
    check("partial_err", 32'(partial_error), 32'h1);
    check("partial_no_valid", 32'(word_valid), 32'h0);
    clear();
    check("partial_cleared", 32'(w_errors), 32'h0);

`ifdef BEP_PARITY_EN
    send_byte(8'hA5, 1'b0, 1'b0);
    check("parity_ok_valid", 32'(word_valid), 32'h1);
    check("parity_ok_data", 32'(word_data), 32'hA5);
    check("parity_ok_err", 32'(parity_error), 32'h0);
    accept();
    wait_frame_end("parity_ok_frame_end");
    send_byte(8'hA5, 1'b0, 1'b1);
    check("parity_bad_err", 32'(parity_error), 32'h1);
    check("parity_bad_no_valid", 32'(word_valid), 32'h0);
    wait_frame_end("parity_bad_frame_end");
    clear();
`endif

    // Asynchronous reset in the middle of bit 4 of the second word
    send_byte(8'h5A, 1'b0, 1'b0);
    pulse(18, 10, 1'b0);
    pulse(9, 10, 1'b0);
    pulse(18, 10, 1'b0);
    digital_in = 1'b1;
    tick(5);
    check("pre_reset_status", 32'(w_status), 32'h60);
    reset_n    = 1'b0;
    digital_in = 1'b0;
    #1;
    check("async_reset_status", 32'(w_status), 32'h0);
    check("async_reset_data", 32'(word_data), 32'h0);
    tick(3);
    reset_n = 1'b1;
    tick(2);
    send_byte(8'h3C, 1'b0, 1'b0);
    check("post_reset_valid", 32'(word_valid), 32'h1);
    check("post_reset_data", 32'(word_data), 32'h3C);
    accept();
    wait_frame_end("post_reset_frame_end");
    check("post_reset_errors", 32'(w_errors), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
